dac_command_fsm: RTL and testbench

DAC_COMMAND_FSM -- requirements
Module: dac_command_fsm

---
 rtl/dac_command_fsm.sv | 219 +++++++++++++++++++++
 tb/tb_dac_command_fsm.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_command_fsm.sv
// UART command parser driving an I2C DAC: "V<ch><bits>" writes a channel code,
// "v<ch>" reads back the last written code as ASCII bits plus a newline.
module dac_command_fsm #(
  parameter int         DAC_BITS    = 10,
  parameter int         NUM_CH      = 4,
  parameter logic [6:0] ADDR_BASE   = 7'b0001101,
  parameter int         PAD_BITS    = 2,
  parameter int         ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  UART_Rx,
  input  logic        UART_DataReady,
  output logic [7:0]  UART_Tx,
  output logic        UART_TxLoad,
  input  logic        UART_TxBusy,
  output logic [6:0]  I2Caddr,
  output logic [15:0] I2Cdata,
  output logic        I2Cbytes,
  output logic        I2Cr_w,
  output logic        I2C_load,
  input  logic        I2CBusy,
  output logic        CmdError
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BCNT_W = $clog2(DAC_BITS + 1);
  localparam int TCNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int CNT_W  = (BCNT_W > TCNT_W) ? BCNT_W : TCNT_W;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_UV = 8'h56;
  localparam logic [7:0] ASCII_LV = 8'h76;
  localparam logic [7:0] ASCII_NL = 8'h0A;

  typedef enum logic [3:0] {
    IDLE, GET_CH_W, GET_CH_R, GET_BITS, WAIT_FREE,
    LOAD, WAIT_ACK, WAIT_DONE, TX_BIT, TX_NL
  } state_e;

  state_e               state_q, state_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [DAC_BITS-1:0]  code_q, code_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DAC_BITS-1:0]  shadow_q [NUM_CH];
  logic [DAC_BITS-1:0]  shadow_d [NUM_CH];
  logic [7:0]           tx_q, tx_d;
  logic                 tx_load_q, tx_load_d;
  logic [6:0]           addr_q, addr_d;
  logic [15:0]          data_q, data_d;
  logic                 i2c_load_q, i2c_load_d;
  logic                 err_q, err_d;

  logic            rx_is_bit, rx_is_ch, tx_ready, bits_last, ack_last;
  logic [CH_W-1:0] rx_ch;

  assign rx_is_bit = (UART_Rx == ASCII_0) || (UART_Rx == ASCII_1);
  assign rx_is_ch  = (UART_Rx >= ASCII_0) && (UART_Rx < 8'(ASCII_0 + NUM_CH));
  // ASCII '0'..'7' carry the digit value in their low three bits.
  assign rx_ch     = UART_Rx[CH_W-1:0];
  assign tx_ready  = !UART_TxBusy && !tx_load_q;
  assign bits_last = (cnt_q == CNT_W'(DAC_BITS - 1));
  assign ack_last  = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    tx_d       = tx_q;
    tx_load_d  = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    i2c_load_d = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (UART_DataReady) begin
          if (UART_Rx == ASCII_UV)      state_d = GET_CH_W;
          else if (UART_Rx == ASCII_LV) state_d = GET_CH_R;
        end
      end

      GET_CH_W, GET_CH_R: begin
        if (UART_DataReady) begin
          if (rx_is_ch) begin
            ch_d  = rx_ch;
            cnt_d = '0;
            if (state_q == GET_CH_W) begin
              state_d = GET_BITS;
            end else begin
              // The code register doubles as the readback shift register.
              code_d  = shadow_q[rx_ch];
              state_d = TX_BIT;
            end
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      GET_BITS: begin
        if (UART_DataReady) begin
          if (rx_is_bit) begin
            code_d = (code_q << 1) | DAC_BITS'(UART_Rx[0]);
            cnt_d  = cnt_q + CNT_W'(1);
            if (bits_last) state_d = WAIT_FREE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      WAIT_FREE: begin
        if (!I2CBusy) begin
          i2c_load_d       = 1'b1;
          addr_d           = ADDR_BASE + 7'(ch_q);
          data_d           = 16'(code_q) << PAD_BITS;
          shadow_d[ch_q]   = code_q;
          state_d          = LOAD;
        end
      end

      LOAD: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (I2CBusy) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (ack_last) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_DONE: begin
        if (!I2CBusy) begin
          state_d = IDLE;
        end else if (ack_last) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      TX_BIT: begin
        if (tx_ready) begin
          tx_d      = ASCII_0 | 8'(code_q[DAC_BITS-1]);
          tx_load_d = 1'b1;
          code_d    = code_q << 1;
          cnt_d     = cnt_q + CNT_W'(1);
          if (bits_last) state_d = TX_NL;
        end
      end

      TX_NL: begin
        if (tx_ready) begin
          tx_d      = ASCII_NL;
          tx_load_d = 1'b1;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      code_q     <= '0;
      cnt_q      <= '0;
      // NOTE: the shadow array is a handful of flops and must read back 0 after reset, so it is reset explicitly.
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
      tx_q       <= '0;
      tx_load_q  <= 1'b0;
      addr_q     <= ADDR_BASE;
      data_q     <= '0;
      i2c_load_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      tx_q       <= tx_d;
      tx_load_q  <= tx_load_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      i2c_load_q <= i2c_load_d;
      err_q      <= err_d;
    end
  end

  assign UART_Tx     = tx_q;
  assign UART_TxLoad = tx_load_q;
  assign I2Caddr     = addr_q;
  assign I2Cdata     = data_q;
  assign I2Cbytes    = 1'b1;
  assign I2Cr_w      = 1'b0;
  assign I2C_load    = i2c_load_q;
  assign CmdError    = err_q;

endmodule

// File: tb/tb_dac_command_fsm.sv
// Directed bench for dac_command_fsm with simple UART-transmitter and I2C-master models.
`timescale 1ns/1ps
module tb_dac_command_fsm;

  localparam int         DAC_BITS    = 10;
  localparam int         NUM_CH      = 4;
  localparam logic [6:0] ADDR_BASE   = 7'b0001101;
  localparam int         PAD_BITS    = 2;
  localparam int         ACK_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  UART_Rx = 8'h00;
  logic        UART_DataReady = 1'b0;
  logic [7:0]  UART_Tx;
  logic        UART_TxLoad;
  logic        UART_TxBusy = 1'b0;
  logic [6:0]  I2Caddr;
  logic [15:0] I2Cdata;
  logic        I2Cbytes;
  logic        I2Cr_w;
  logic        I2C_load;
  logic        I2CBusy = 1'b0;
  logic        CmdError;

  int checks = 0;
  int errors = 0;

  dac_command_fsm #(
    .DAC_BITS(DAC_BITS), .NUM_CH(NUM_CH), .ADDR_BASE(ADDR_BASE),
    .PAD_BITS(PAD_BITS), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .UART_Rx(UART_Rx), .UART_DataReady(UART_DataReady),
    .UART_Tx(UART_Tx), .UART_TxLoad(UART_TxLoad), .UART_TxBusy(UART_TxBusy),
    .I2Caddr(I2Caddr), .I2Cdata(I2Cdata), .I2Cbytes(I2Cbytes), .I2Cr_w(I2Cr_w),
    .I2C_load(I2C_load), .I2CBusy(I2CBusy), .CmdError(CmdError)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Peripheral models and event recorders, all sampled on the falling edge.
  logic [7:0]  tx_bytes[$];
  int          uart_cnt = 0;
  logic        prev_txload = 1'b0;
  int          spacing_err = 0;
  int          both_high = 0;
  int          i2c_loads = 0;
  logic [6:0]  cap_addr = '0;
  logic [15:0] cap_data = '0;
  int          load_cyc = 0;
  int          err_pulses = 0;
  int          err_cyc = 0;
  int          i2c_cnt = 0;
  logic        hold_busy = 1'b0;
  logic        auto_ack = 1'b1;

  always @(negedge clk) begin
    if (UART_TxLoad) begin
      if (UART_TxBusy || prev_txload) spacing_err++;
      tx_bytes.push_back(UART_Tx);
      uart_cnt = 4;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
    end
    prev_txload = UART_TxLoad;
    UART_TxBusy = (uart_cnt != 0);

    if (I2C_load) begin
      i2c_loads++;
      cap_addr = I2Caddr;
      cap_data = I2Cdata;
      load_cyc = cyc;
      if (auto_ack) i2c_cnt = 8;
    end else if (i2c_cnt > 0) begin
      i2c_cnt--;
    end
    if (I2C_load && UART_TxLoad) both_high++;
    if (CmdError) begin
      err_pulses++;
      err_cyc = cyc;
    end
    I2CBusy = hold_busy || (i2c_cnt != 0 && i2c_cnt < 7);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    UART_Rx = b;
    UART_DataReady = 1'b1;
    @(negedge clk);
    UART_DataReady = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_write(input int ch, input logic [DAC_BITS-1:0] code);
    send_byte(8'h56);
    send_byte(8'h30 + 8'(ch));
    for (int i = DAC_BITS - 1; i >= 0; i--) send_byte(8'h30 | 8'(code[i]));
  endtask

  // Issues "v<ch>" and compares the returned bytes with the expected code and newline.
  task automatic expect_readback(input int ch, input logic [DAC_BITS-1:0] exp, input string name);
    int base;
    logic [7:0] want;
    base = tx_bytes.size();
    send_byte(8'h76);
    send_byte(8'h30 + 8'(ch));
    for (int i = 0; i < 400 && tx_bytes.size() < base + DAC_BITS + 1; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++;
    if (tx_bytes.size() !== base + DAC_BITS + 1) begin
      errors++;
      $display("FAIL %s byte_count: got %0d expected %0d", name, tx_bytes.size() - base, DAC_BITS + 1);
    end else begin
      for (int i = 0; i <= DAC_BITS; i++) begin
        want = (i < DAC_BITS) ? (8'h30 | 8'(exp[DAC_BITS-1-i])) : 8'h0A;
        checks++;
        if (tx_bytes[base+i] !== want) begin
          errors++;
          $display("FAIL %s byte%0d: got %h expected %h", name, i, tx_bytes[base+i], want);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({UART_TxLoad, I2C_load, CmdError} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 000", {UART_TxLoad, I2C_load, CmdError});
    end
    checks++;
    if (I2Caddr !== ADDR_BASE || I2Cdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_i2c_regs: got addr %h data %h expected %h 0000", I2Caddr, I2Cdata, ADDR_BASE);
    end
    checks++;
    if (I2Cbytes !== 1'b1 || I2Cr_w !== 1'b0) begin
      errors++;
      $display("FAIL const_outputs: got bytes %b r_w %b expected 1 0", I2Cbytes, I2Cr_w);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_garbage();
    int e0;
    e0 = err_pulses;
    send_byte(8'h78);
    send_byte(8'h41);
    send_byte(8'h31);
    repeat (3) @(negedge clk);
    checks++;
    if (err_pulses !== e0) begin
      errors++;
      $display("FAIL idle_garbage_err: got %0d pulses expected 0", err_pulses - e0);
    end
  endtask

  task automatic test_bad_channel();
    int e0, l0;
    e0 = err_pulses;
    l0 = i2c_loads;
    send_byte(8'h56);
    send_byte(8'h35);
    repeat (5) @(negedge clk);
    checks++;
    if (err_pulses !== e0 + 1) begin
      errors++;
      $display("FAIL bad_channel_err: got %0d pulses expected 1", err_pulses - e0);
    end
    checks++;
    if (i2c_loads !== l0) begin
      errors++;
      $display("FAIL bad_channel_load: got %0d loads expected 0", i2c_loads - l0);
    end
    expect_readback(0, 10'b0000000000, "bad_channel_rb0");
  endtask

  task automatic test_write();
    int e0, l0, t0;
    e0 = err_pulses;
    l0 = i2c_loads;
    t0 = tx_bytes.size();
    hold_busy = 1'b1;
    send_write(2, 10'b1010101010);
    repeat (20) @(negedge clk);
    // Readback request arriving while the write is pending must be dropped.
    send_byte(8'h76);
    send_byte(8'h30);
    checks++;
    if (i2c_loads !== l0) begin
      errors++;
      $display("FAIL wait_free_hold: got %0d loads expected 0", i2c_loads - l0);
    end
    hold_busy = 1'b0;
    for (int i = 0; i < 50 && i2c_loads == l0; i++) @(negedge clk);
    checks++;
    if (i2c_loads !== l0 + 1) begin
      errors++;
      $display("FAIL write_load_count: got %0d expected 1", i2c_loads - l0);
    end
    checks++;
    if (cap_addr !== 7'h0F || cap_data !== 16'h0AA8) begin
      errors++;
      $display("FAIL write_load_value: got addr %h data %h expected 0f 0aa8", cap_addr, cap_data);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (I2Caddr !== 7'h0F || I2Cdata !== 16'h0AA8) begin
      errors++;
      $display("FAIL write_hold_value: got addr %h data %h expected 0f 0aa8", I2Caddr, I2Cdata);
    end
    checks++;
    if (err_pulses !== e0 || i2c_loads !== l0 + 1 || tx_bytes.size() !== t0) begin
      errors++;
      $display("FAIL write_side_effects: got err %0d loads %0d tx %0d expected 0 1 0",
               err_pulses - e0, i2c_loads - l0, tx_bytes.size() - t0);
    end
  endtask

  task automatic test_readback();
    expect_readback(2, 10'b1010101010, "readback_ch2");
  endtask

  task automatic test_bad_bit();
    int e0, l0;
    e0 = err_pulses;
    l0 = i2c_loads;
    send_byte(8'h56);
    send_byte(8'h31);
    send_byte(8'h31);
    send_byte(8'h30);
    send_byte(8'h78);
    repeat (3) @(negedge clk);
    checks++;
    if (err_pulses !== e0 + 1 || i2c_loads !== l0) begin
      errors++;
      $display("FAIL bad_bit: got err %0d loads %0d expected 1 0", err_pulses - e0, i2c_loads - l0);
    end
    send_write(3, 10'b0000011111);
    for (int i = 0; i < 50 && i2c_loads == l0; i++) @(negedge clk);
    checks++;
    if (i2c_loads !== l0 + 1 || cap_addr !== 7'h10 || cap_data !== 16'h007C) begin
      errors++;
      $display("FAIL after_bad_bit_write: got loads %0d addr %h data %h expected 1 10 007c",
               i2c_loads - l0, cap_addr, cap_data);
    end
    repeat (30) @(negedge clk);
    expect_readback(3, 10'b0000011111, "readback_ch3");
  endtask

  task automatic test_timeout();
    int e0, l0;
    e0 = err_pulses;
    l0 = i2c_loads;
    auto_ack = 1'b0;
    send_write(1, 10'b1100110011);
    for (int i = 0; i < 50 && i2c_loads == l0; i++) @(negedge clk);
    checks++;
    if (i2c_loads !== l0 + 1 || cap_addr !== 7'h0E || cap_data !== 16'h0CCC) begin
      errors++;
      $display("FAIL timeout_load: got loads %0d addr %h data %h expected 1 0e 0ccc",
               i2c_loads - l0, cap_addr, cap_data);
    end
    for (int i = 0; i < 400 && err_pulses == e0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (err_pulses !== e0 + 1) begin
      errors++;
      $display("FAIL timeout_err_count: got %0d expected 1", err_pulses - e0);
    end
    // LOAD cycle plus ACK_TIMEOUT cycles in WAIT_ACK precede the error pulse.
    checks++;
    if (err_cyc - load_cyc !== ACK_TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d expected %0d", err_cyc - load_cyc, ACK_TIMEOUT + 1);
    end
    auto_ack = 1'b1;
    expect_readback(1, 10'b1100110011, "timeout_readback");
  endtask

  task automatic test_reset_mid_readback();
    int base;
    base = tx_bytes.size();
    send_byte(8'h76);
    send_byte(8'h32);
    for (int i = 0; i < 300 && tx_bytes.size() < base + 4; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({UART_TxLoad, I2C_load, CmdError} !== 3'b000 || I2Caddr !== ADDR_BASE || I2Cdata !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_outputs: got strobes %b addr %h data %h expected 000 %h 0000",
               {UART_TxLoad, I2C_load, CmdError}, I2Caddr, I2Cdata, ADDR_BASE);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (tx_bytes.size() !== base + 4) begin
      errors++;
      $display("FAIL mid_reset_tx_stop: got %0d bytes expected 4", tx_bytes.size() - base);
    end
    for (int ch = 0; ch < NUM_CH; ch++) expect_readback(ch, '0, $sformatf("post_reset_ch%0d", ch));
  endtask

  task automatic test_protocol_rules();
    checks++;
    if (spacing_err !== 0) begin
      errors++;
      $display("FAIL tx_spacing: got %0d violations expected 0", spacing_err);
    end
    checks++;
    if (both_high !== 0) begin
      errors++;
      $display("FAIL load_overlap: got %0d overlaps expected 0", both_high);
    end
  endtask

  initial begin
    test_reset();
    test_idle_garbage();
    test_bad_channel();
    test_write();
    test_readback();
    test_bad_bit();
    test_timeout();
    test_reset_mid_readback();
    test_protocol_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
